// File: rtl/array_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : array_delay_line
//  Description : Multi-lane fixed-latency delay line. It has DEPTH stages and
//                N lanes of W bits each. Lanes are masked per capture, and the
//                pipeline supports hold and flush. The block reports a
//                registered OR of the output data and an occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_delay_line #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DEPTH = 3
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         hold,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [N*W-1:0]               in_data,
    input  logic [N-1:0]                 lane_en,
    output logic                         out_valid,
    output logic [N*W-1:0]               out_data,
    output logic                         q,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int C_FILL_W = $clog2(DEPTH + 1);

    // Stage storage: data and valid bit per stage.
    logic [W-1:0]          r_data [0:DEPTH-1][0:N-1];
    logic [0:DEPTH-1]      r_valid;
    logic                  r_q;
    logic [C_FILL_W-1:0]   r_fill;

    // Masked lanes that stage 0 would capture on this edge.
    logic [W-1:0]          w_stage0 [0:N-1];
    // The content that will move into the last stage on a shifting edge.
    logic [W-1:0]          w_prev_data [0:N-1];
    logic                  w_prev_valid;
    logic                  w_next_q;
    logic [C_FILL_W-1:0]   w_next_fill;

    // Build stage-0 capture value; disabled lanes load zero.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_stage0[k] = lane_en[k] ? in_data[k*W +: W] : '0;
        end
    end

    // Select the source of the last stage. With a single stage, that source
    // is the input itself.
    generate
        if (DEPTH == 1) begin : g_single_stage
            // Last stage is fed directly from the masked input.
            always_comb begin
                w_prev_valid = in_valid;
                for (int k = 0; k < N; k++) begin
                    w_prev_data[k] = w_stage0[k];
                end
            end
        end else begin : g_multi_stage
            // Last stage is fed from the stage just before it.
            always_comb begin
                w_prev_valid = r_valid[DEPTH-2];
                for (int k = 0; k < N; k++) begin
                    w_prev_data[k] = r_data[DEPTH-2][k];
                end
            end
        end
    endgenerate

    // Compute q and fill for a shifting edge. q is taken from the incoming
    // last-stage value, so it lines up with out_valid/out_data.
    always_comb begin
        w_next_q = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_next_q = w_next_q | (|w_prev_data[k]);
        end
        w_next_q    = w_next_q & w_prev_valid;
        w_next_fill = r_fill + C_FILL_W'(in_valid) - C_FILL_W'(r_valid[DEPTH-1]);
    end

    // Pipeline update. Priority is reset, then flush, then hold, then shift.
    // Flush clears only the valid bits; stale data behind a cleared valid bit
    // is harmless.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int k = 0; k < N; k++) begin
                    r_data[s][k] <= '0;
                end
            end
            r_valid <= '0;
            r_q     <= 1'b0;
            r_fill  <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_q     <= 1'b0;
            r_fill  <= '0;
        end else if (!hold) begin
            for (int k = 0; k < N; k++) begin
                r_data[0][k] <= w_stage0[k];
            end
            r_valid[0] <= in_valid;
            for (int s = 1; s < DEPTH; s++) begin
                r_valid[s] <= r_valid[s-1];
                for (int k = 0; k < N; k++) begin
                    r_data[s][k] <= r_data[s-1][k];
                end
            end
            r_q    <= w_next_q;
            r_fill <= w_next_fill;
        end
    end

    // Repack the last stage into the flat output bus.
    generate
        for (genvar k = 0; k < N; k++) begin : g_out_lane
            assign out_data[k*W +: W] = r_data[DEPTH-1][k];
        end
    endgenerate

    assign out_valid = r_valid[DEPTH-1];
    assign q         = r_q;
    assign fill      = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_array_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_delay_line
//  Description : Self-checking bench for array_delay_line. It runs three
//                configurations side by side: the defaults, the smallest
//                (1x1x1) and the largest (16x32x8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_array_delay_line;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst, hold, flush, in_valid;
    logic [511:0]  in_data;
    logic [15:0]   lane_en;

    logic          v0, q0;
    logic [31:0]   d0;
    logic [1:0]    f0;
    logic          v1, q1;
    logic [0:0]    d1;
    logic [0:0]    f1;
    logic          v2, q2;
    logic [511:0]  d2;
    logic [3:0]    f2;

    int vectors     = 0;
    int miscompares = 0;

    array_delay_line #(.N(4), .W(8), .DEPTH(3)) u_dut0 (
        .clock(clock), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[31:0]), .lane_en(lane_en[3:0]),
        .out_valid(v0), .out_data(d0), .q(q0), .fill(f0)
    );

    array_delay_line #(.N(1), .W(1), .DEPTH(1)) u_dut1 (
        .clock(clock), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[0:0]), .lane_en(lane_en[0:0]),
        .out_valid(v1), .out_data(d1), .q(q1), .fill(f1)
    );

    array_delay_line #(.N(16), .W(32), .DEPTH(8)) u_dut2 (
        .clock(clock), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .lane_en(lane_en),
        .out_valid(v2), .out_data(d2), .q(q2), .fill(f2)
    );

    // Reference model: one queue of DEPTH entries per configuration.
    // The front entry is the newest capture; the back entry is the output.
    typedef struct packed {
        logic         v;
        logic [511:0] d;
    } ent_t;

    ent_t mq [3][$];

    function automatic int cfg_n(int c);
        return (c == 0) ? 4 : (c == 1) ? 1 : 16;
    endfunction

    function automatic int cfg_w(int c);
        return (c == 0) ? 8 : (c == 1) ? 1 : 32;
    endfunction

    function automatic int cfg_d(int c);
        return (c == 0) ? 3 : (c == 1) ? 1 : 8;
    endfunction

    function automatic logic [511:0] masked_input(int c);
        logic [511:0] r;
        int w;
        r = '0;
        w = cfg_w(c);
        for (int b = 0; b < 512; b++) begin
            if (b < cfg_n(c) * w) r[b] = in_data[b] & lane_en[b / w];
        end
        return r;
    endfunction

    task automatic model_edge();
        ent_t e;
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                mq[c].delete();
                e.v = 1'b0;
                e.d = '0;
                for (int i = 0; i < cfg_d(c); i++) mq[c].push_back(e);
            end else if (flush) begin
                for (int i = 0; i < mq[c].size(); i++) begin
                    e = mq[c][i];
                    e.v = 1'b0;
                    mq[c][i] = e;
                end
            end else if (!hold) begin
                e.v = in_valid;
                e.d = masked_input(c);
                mq[c].push_front(e);
                void'(mq[c].pop_back());
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_data = {16{$urandom()}}; lane_en = 16'hFFFF;
        tick();
        tick();
        vectors++;
        if ({v0, d0, q0, f0} !== '0) begin
            miscompares++;
            $display("FAIL reset_dut0: got v=%b d=%h q=%b f=%0d required all zero", v0, d0, q0, f0);
        end
        vectors++;
        if ({v2, d2, q2, f2} !== '0 || {v1, d1, q1, f1} !== '0) begin
            miscompares++;
            $display("FAIL reset_sweep: got v1=%b q1=%b f1=%0d v2=%b q2=%b f2=%0d required all zero",
                     v1, q1, f1, v2, q2, f2);
        end
        idle_inputs();
    endtask

    task automatic test_latency();
        in_data = '0; in_data[31:0] = 32'h0403_0201; lane_en = 16'h000F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) tick();
            vectors++;
            if (v0 !== (i == 3)) begin
                miscompares++;
                $display("FAIL latency_valid_c%0d: got %b required %b", i, v0, (i == 3));
            end
        end
        vectors++;
        if (d0 !== 32'h0403_0201 || q0 !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_data: got d=%h q=%b required d=04030201 q=1", d0, q0);
        end
        tick();
        vectors++;
        if (f0 !== 2'd0 || v0 !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_drain: got fill=%0d v=%b required fill=0 v=0", f0, v0);
        end
    endtask

    task automatic test_masking();
        in_data = '0; in_data[31:0] = 32'hFFFF_FFFF; lane_en = 16'h0005; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if (v0 !== 1'b1 || d0 !== 32'h00FF_00FF) begin
            miscompares++;
            $display("FAIL lane_mask: got v=%b d=%h required v=1 d=00ff00ff", v0, d0);
        end
        tick();
        lane_en = 16'h000F;
    endtask

    task automatic test_hold();
        logic [31:0] vals [3];
        for (int i = 0; i < 3; i++) vals[i] = $urandom() | 32'h1;
        lane_en = 16'h000F;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data[31:0] = vals[i];
            tick();
        end
        vectors++;
        if (v0 !== 1'b1 || d0 !== vals[0] || f0 !== 2'd3) begin
            miscompares++;
            $display("FAIL hold_prefill: got v=%b d=%h f=%0d required v=1 d=%h f=3", v0, d0, f0, vals[0]);
        end
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data[31:0] = $urandom();
            tick();
            vectors++;
            if (v0 !== 1'b1 || d0 !== vals[0] || f0 !== 2'd3 || q0 !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_frozen_c%0d: got v=%b d=%h f=%0d q=%b required v=1 d=%h f=3 q=1",
                         i, v0, d0, f0, q0, vals[0]);
            end
        end
        hold = 1'b0; in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            tick();
            vectors++;
            if (v0 !== 1'b1 || d0 !== vals[i]) begin
                miscompares++;
                $display("FAIL hold_release_%0d: got v=%b d=%h required v=1 d=%h", i, v0, d0, vals[i]);
            end
        end
        tick();
        vectors++;
        if (v0 !== 1'b0 || f0 !== 2'd0) begin
            miscompares++;
            $display("FAIL hold_no_dup: got v=%b f=%0d required v=0 f=0", v0, f0);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[31:0] = $urandom();
            tick();
        end
        vectors++;
        if (f0 !== 2'd3) begin
            miscompares++;
            $display("FAIL flush_prefill: got fill=%0d required 3", f0);
        end
        flush = 1'b1; hold = 1'b1; in_valid = 1'b1; in_data[31:0] = 32'hDEAD_BEEF;
        tick();
        vectors++;
        if (f0 !== 2'd0 || v0 !== 1'b0 || q0 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got fill=%0d v=%b q=%b required 0 0 0", f0, v0, q0);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (v0 !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_emerge_c%0d: got v=%b d=%h required v=0", i, v0, d0);
            end
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data[31:0] = $urandom() | 32'h1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (f0 !== 2'd2) begin
            miscompares++;
            $display("FAIL midrst_prefill: got fill=%0d required 2", f0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({v0, d0, q0, f0} !== '0) begin
            miscompares++;
            $display("FAIL midrst_clear: got v=%b d=%h q=%b f=%0d required all zero", v0, d0, q0, f0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (v0 !== 1'b0 || f0 !== 2'd0) begin
                miscompares++;
                $display("FAIL midrst_quiet_c%0d: got v=%b f=%0d required v=0 f=0", i, v0, f0);
            end
        end
    endtask

    task automatic test_random_sweep();
        logic         av, aq, ev, eq;
        logic [511:0] ad, ed;
        int           af, ef, last;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            hold     = ($urandom_range(0, 3) == 0);
            in_valid = $urandom_range(0, 1);
            lane_en  = 16'($urandom());
            for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = $urandom();
            tick();
            for (int c = 0; c < 3; c++) begin
                ad = '0;
                case (c)
                    0: begin av = v0; aq = q0; ad[31:0] = d0; af = int'(f0); end
                    1: begin av = v1; aq = q1; ad[0:0]  = d1; af = int'(f1); end
                    default: begin av = v2; aq = q2; ad = d2; af = int'(f2); end
                endcase
                last = mq[c].size() - 1;
                ev = mq[c][last].v;
                ed = mq[c][last].d;
                eq = ev & (|ed);
                ef = 0;
                for (int i = 0; i <= last; i++) if (mq[c][i].v) ef++;
                vectors++;
                if (av !== ev || aq !== eq || af !== ef || (ev && ad !== ed) || af > cfg_d(c)) begin
                    miscompares++;
                    $display("FAIL random_cfg%0d_cyc%0d: got v=%b q=%b f=%0d d=%h required v=%b q=%b f=%0d d=%h",
                             c, cyc, av, aq, af, ad, ev, eq, ef, ed);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; lane_en = '0;
        test_reset();
        test_latency();
        test_masking();
        test_hold();
        test_flush();
        test_reset_midstream();
        test_random_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
